// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Two-entry pipeline stage with a skid register. The handshake
//               outputs are decoded from registered state only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter int unsigned     Size       = 64,
  parameter logic [Size-1:0] ResetValue = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [Size-1:0] data_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [Size-1:0] data_o,
  input  logic            ready_i,
  output logic [1:0]      count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          r_state;
  logic [Size-1:0] r_main;
  logic [Size-1:0] r_skid;
  logic            w_in_fire;
  logic            w_out_fire;

  // State encoding doubles as the occupancy count.
  assign ready_o    = (r_state != TWO);
  assign valid_o    = (r_state != EMPTY);
  assign count_o    = r_state;
  assign data_o     = r_main;
  assign w_in_fire  = valid_i & ready_o;
  assign w_out_fire = valid_o & ready_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= EMPTY;
      r_main  <= ResetValue;
      r_skid  <= ResetValue;
    end else if (flush_i) begin
      // Data registers keep their contents; only occupancy is discarded.
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main  <= data_i;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= data_i;
          end else if (w_in_fire) begin
            r_skid  <= data_i;
            r_state <= TWO;
          end else if (w_out_fire) begin
            r_state <= EMPTY;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            r_main  <= r_skid;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter Size, default 64, giving the data width in bits.
REQ-002 SHALL have parameter ResetValue, default 0, giving the value of both data registers after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL have port flush_i, input, 1, synchronous discard of all held entries.
REQ-006 SHALL have port valid_i, input, 1, upstream data valid.
REQ-007 SHALL have port data_i, input, Size, upstream data.
REQ-008 SHALL have port ready_o, output, 1, stage can accept data this cycle.
REQ-009 SHALL have port valid_o, output, 1, data_o holds a valid entry.
REQ-010 SHALL have port data_o, output, Size, oldest held entry.
REQ-011 SHALL have port ready_i, input, 1, downstream accepts data_o this cycle.
REQ-012 SHALL have port count_o, output, 2, number of held entries (0..2).

Function
REQ-013 SHALL hold up to two entries: a main register driving data_o and a skid register.
REQ-014 SHALL implement states EMPTY (0 entries), ONE (main full), TWO (main and skid full); count_o = 0/1/2 respectively.
REQ-015 SHALL define in_fire = valid_i & ready_o and out_fire = valid_o & ready_i.
REQ-016 SHALL drive ready_o = 1 in EMPTY and ONE, and 0 in TWO, decoded only from state (no combinational path from ready_i or valid_i).
REQ-017 SHALL drive valid_o = 1 in ONE and TWO, and 0 in EMPTY, decoded only from state.
REQ-018 EMPTY: on in_fire, main <= data_i, go to ONE; otherwise hold.
REQ-019 ONE, in_fire & out_fire: main <= data_i, stay in ONE.
REQ-020 ONE, in_fire & !out_fire: skid <= data_i, go to TWO; main unchanged.
REQ-021 ONE, !in_fire & out_fire: go to EMPTY; main value unchanged.
REQ-022 TWO, out_fire: main <= skid, go to ONE; otherwise hold both registers.
REQ-023 SHALL deliver entries in acceptance order with no loss or duplication; latency from in_fire to valid_o in EMPTY is 1 cycle.
REQ-024 SHALL NOT change data_o while valid_o = 1 and ready_i = 0.
REQ-025 flush_i = 1 SHALL have priority over all transitions: next state EMPTY, concurrent in_fire dropped; data register contents unchanged.
REQ-026 Data registers SHALL be written only on the transitions listed above; data_i is ignored when in_fire = 0.

Reset
REQ-027 While reset = 0, asynchronously and without waiting for clk: state = EMPTY, main = skid = ResetValue, valid_o = 0, count_o = 0, ready_o = 1, data_o = ResetValue.
REQ-028 Assertion of reset mid-operation (in ONE or TWO) SHALL discard all entries immediately.
REQ-029 After reset deasserts, the first rising edge of clk SHALL act normally per REQ-018.

Verification
REQ-030 Reset: reset = 0 with state TWO, asserted between clock edges -> valid_o = 0, count_o = 0, data_o = 0 before the next edge.
REQ-031 Pass-through: ready_i = 1, inputs 0x1111_..._1111, then 0x2222_..._2222 on consecutive cycles -> data_o shows each value one cycle later, count_o stays at 1 and ready_o stays at 1.
REQ-032 Backpressure: ready_i = 0, present A = 0xAAAA..., B = 0xBBBB..., C = 0xCCCC... -> A and B accepted, count_o = 2, ready_o = 0, C not accepted, data_o = A steady.
REQ-033 Drain: from REQ-032, raise ready_i for 2 cycles -> data_o = A then B, count_o goes 2 -> 1 -> 0, ready_o returns to 1 after the first pop.
REQ-034 Flush: count_o = 2, then assert flush_i with valid_i = 1 for 1 cycle -> count_o = 0, valid_o = 0, and the concurrent input is not delivered.
REQ-035 Random: 1000 random 64-bit values with random valid_i and ready_i -> the output sequence equals the accepted input sequence exactly, with zero errors reported.
